// File: rtl/ec_gen.sv
// Count-enable generator for the gated-clock counter: debounced single-step or
// prescaled free-run pulses on the active-low EC, retimed on the falling edge.
module ec_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PRESCALE        = 10
) (
    input  logic       clk,
    input  logic       r,
    input  logic       key,
    input  logic       run,
    output logic       EC,
    output logic       key_db,
    output logic [1:0] mode
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        StStep  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    logic          key_s1_q, key_s2_q;
    logic          run_s1_q, run_s2_q;
    logic [DW-1:0] dbc_q, dbc_d;
    logic          db_q, db_d;
    logic          db_dly_q;
    logic [PW-1:0] presc_q, presc_d;
    state_e        state_q, state_d;
    logic          press;
    logic          request;
    logic          ec_q;

    assign press  = db_q & ~db_dly_q;
    assign key_db = db_q;
    assign mode   = state_q;
    assign EC     = ec_q;

    // The counter only needs DEBOUNCE_CYCLES-1 as its top value: the final
    // stable sample flips key_db directly instead of being stored.
    always_comb begin
        dbc_d = '0;
        db_d  = db_q;
        if (key_s2_q != db_q) begin
            if (dbc_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = key_s2_q;
            end else begin
                dbc_d = dbc_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        request = 1'b0;
        unique case (state_q)
            StStep: begin
                presc_d = '0;
                if (run_s2_q) begin
                    state_d = StRun;
                end else if (press) begin
                    request = 1'b1;
                end
            end
            StRun: begin
                if (!run_s2_q) begin
                    state_d = StStep;
                    presc_d = '0;
                end else if (press) begin
                    // Freeze at the current count so resume continues from here.
                    state_d = StPause;
                end else begin
                    request = (presc_q == PW'(PRESCALE - 1));
                    presc_d = request ? '0 : presc_q + 1'b1;
                end
            end
            StPause: begin
                if (!run_s2_q) begin
                    state_d = StStep;
                    presc_d = '0;
                end else if (press) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StStep;
                presc_d = '0;
            end
        endcase
        if (r) begin
            request = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            dbc_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            presc_q  <= '0;
            state_q  <= StStep;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            run_s1_q <= run;
            run_s2_q <= run_s1_q;
            dbc_q    <= dbc_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
            presc_q  <= presc_d;
            state_q  <= state_d;
        end
    end

    // Falling-edge retiming keeps EC stable across the whole clk-high phase.
    always_ff @(negedge clk) begin
        if (r) begin
            ec_q <= 1'b1;
        end else begin
            ec_q <= ~request;
        end
    end

endmodule

// File: tb/tb_ec_gen.sv
// Randomized scoreboard bench for ec_gen: a behavioural model predicts EC at
// every falling edge and key_db/mode after every rising edge.
module tb_ec_gen;

    localparam int D = 4;
    localparam int P = 10;
    localparam int NCYC = 4000;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       key = 1'b1;
    logic       run = 1'b1;
    logic       EC;
    logic       key_db;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    bit       exp_ec_q[$];
    bit [2:0] exp_st_q[$];

    // Model state: two-stage input delay lines, debounce, mode and phase.
    bit m_ks1, m_ks2, m_rs1, m_rs2;
    bit m_db, m_dbd;
    int m_cnt;
    int m_mode;   // 0 step, 1 run, 2 pause
    int m_phase;

    ec_gen #(
        .DEBOUNCE_CYCLES(D),
        .PRESCALE       (P)
    ) dut (
        .clk   (clk),
        .r     (r),
        .key   (key),
        .run   (run),
        .EC    (EC),
        .key_db(key_db),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    function automatic bit model_req(input bit rr);
        bit press;
        press = m_db && !m_dbd;
        if (rr) return 1'b0;
        if (m_mode == 0) return press && !m_rs2;
        if (m_mode == 1) return m_rs2 && !press && (m_phase == P - 1);
        return 1'b0;
    endfunction

    task automatic model_step(input bit rr, input bit kin, input bit rin);
        bit press;
        bit ndb;
        int ncnt;
        if (rr) begin
            m_ks1 = 0; m_ks2 = 0; m_rs1 = 0; m_rs2 = 0;
            m_db = 0; m_dbd = 0; m_cnt = 0; m_mode = 0; m_phase = 0;
            return;
        end
        press = m_db && !m_dbd;
        ndb   = m_db;
        ncnt  = 0;
        if (m_ks2 != m_db) begin
            if (m_cnt + 1 >= D) ndb = m_ks2;
            else ncnt = m_cnt + 1;
        end
        case (m_mode)
            0: begin
                m_phase = 0;
                if (m_rs2) m_mode = 1;
            end
            1: begin
                if (!m_rs2) begin
                    m_mode = 0; m_phase = 0;
                end else if (press) begin
                    m_mode = 2;
                end else begin
                    m_phase = (m_phase + 1) % P;
                end
            end
            default: begin
                if (!m_rs2) begin
                    m_mode = 0; m_phase = 0;
                end else if (press) begin
                    m_mode = 1;
                end
            end
        endcase
        m_dbd = m_db;
        m_db  = ndb;
        m_cnt = ncnt;
        m_ks2 = m_ks1;
        m_ks1 = kin;
        m_rs2 = m_rs1;
        m_rs1 = rin;
    endtask

    initial begin : ec_monitor
        bit e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_ec_q.size() > 0) begin
                e = exp_ec_q.pop_front();
                checks++;
                if (EC !== e) begin
                    errors++;
                    $display("FAIL ec t=%0t got %b want %b", $time, EC, e);
                end
            end
        end
    end

    initial begin : state_monitor
        bit [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_st_q.size() > 0) begin
                e = exp_st_q.pop_front();
                checks += 2;
                if (key_db !== e[2]) begin
                    errors++;
                    $display("FAIL key_db t=%0t got %b want %b", $time, key_db, e[2]);
                end
                if (mode !== e[1:0]) begin
                    errors++;
                    $display("FAIL mode t=%0t got %b want %b", $time, mode, e[1:0]);
                end
            end
        end
    end

    initial begin : stimulus
        int key_hold;
        int run_hold;
        int rst_hold;
        key_hold = 20;
        run_hold = 40;
        rst_hold = 0;
        m_ks1 = 0; m_ks2 = 0; m_rs1 = 0; m_rs2 = 0;
        m_db = 0; m_dbd = 0; m_cnt = 0; m_mode = 0; m_phase = 0;
        @(posedge clk);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #2;
            if (c < 3) begin
                r = 1'b1; key = 1'b1; run = 1'b1;
            end else begin
                if (rst_hold > 0) begin
                    rst_hold--;
                end else if ($urandom_range(0, 399) == 0) begin
                    rst_hold = $urandom_range(0, 2);
                end
                r = (c >= 3 && rst_hold > 0) || (c > 3 && r && rst_hold > 0);
                if (key_hold > 0) begin
                    key_hold--;
                end else begin
                    key = ~key;
                    key_hold = $urandom_range(0, 1) ? $urandom_range(0, 2)
                                                    : $urandom_range(8, 40);
                end
                if (run_hold > 0) begin
                    run_hold--;
                end else begin
                    run = ~run;
                    run_hold = $urandom_range(15, 150);
                end
            end
            exp_ec_q.push_back(!model_req(r));
            model_step(r, key, run);
            exp_st_q.push_back({m_db, 2'(m_mode)});
        end
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_ec_q.size() != 0 || exp_st_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0",
                     exp_ec_q.size(), exp_st_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ec_gen.md
# ec_gen

Count-enable generator for the 4-bit gated-clock counter (`device`). It drives the counter's active-low `EC` input, where the counter's stage clock is `clk & ~EC`. `EC` comes from one of two sources:
- single-step: one pulse per debounced press of the `key` button;
- free-run: a programmable prescaler, which `key` can pause and resume.

The output is retimed so the counter's gated clock never glitches.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a `key` level change; must be ≥1.
- `PRESCALE`, 10: free-run period in `clk` cycles; must be ≥2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge, except the `EC` output flop (falling edge).
- `r` input 1: reset, synchronous, active-high.
- `key` input 1: raw, asynchronous, bouncing push-button level.
- `run` input 1: asynchronous mode select; 0 = step, 1 = free-run.
- `EC` output 1: active-low count enable to the counter; idle 1.
- `key_db` output 1: debounced `key` level.
- `mode` output 2: FSM state; 00 STEP, 01 RUN, 10 PAUSE.

## Operation
- **Synchronization:** `key` and `run` each pass through a 2-flop synchronizer; all logic uses the synchronized copies.
- **Debounce:**
  - Counter increments on each edge where synced `key` ≠ `key_db`, and clears to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, `key_db` takes the synced value and the counter clears.
  - A `press` is the rising edge of `key_db` (`key_db & ~key_db_d`). Releases generate nothing.
- **FSM:**
  - STEP: `press` → request one `EC` pulse. Synced `run`=1 → RUN with prescaler cleared.
  - RUN: prescaler counts 0..`PRESCALE`−1 and wraps; reaching `PRESCALE`−1 requests a pulse. `press` → PAUSE. `run`=0 → STEP.
  - PAUSE: prescaler frozen at its current value, no pulses. `press` → RUN, continuing from the frozen value. `run`=0 → STEP.
  - In STEP the prescaler is held at 0.
- **Simultaneous events:** a change on synced `run` takes priority over `press` in the same cycle, and that `press` is discarded.
- **Pulse limits:** at most one request per cycle; requests never merge or queue.
- **Output:**
  - `EC` is a falling-edge flop loaded with `~request`.
  - It is therefore stable for the whole `clk`-high phase, so `clk & ~EC` produces exactly one clean rising edge per request.
- **Reset (`r`=1):**
  - On the rising edge: synchronizers, debounce counter, prescaler, `key_db` and `key_db_d` → 0; `mode` → 00.
  - On the falling edge: `EC` → 1.
  - Reset values: `EC`=1, `key_db`=0, `mode`=00.
  - A pulse already in progress finishes at its normal falling edge; no new request is issued while `r`=1.

## Timing
- **`key` to `key_db`:** with stable `key`, `key_db` changes at the (`DEBOUNCE_CYCLES`+1)-th rising edge after the edge that first samples the new level (edge 0). This is 2 synchronizer edges plus `DEBOUNCE_CYCLES` counts, less one overlap.
- **`key_db` to `EC` (STEP):** `EC` falls at the falling edge right after `key_db` rises, and returns to 1 one full `clk` period later. The counter advances on the next `clk` high phase.
- **RUN pulse spacing:**
  - The first request comes `PRESCALE` cycles after the edge that enters RUN.
  - Subsequent requests are exactly `PRESCALE` cycles apart.
  - The time spent in PAUSE is excluded from the spacing.
- **`EC` pulse shape:** `EC` is low for exactly one `clk` period per request, and never low for two consecutive periods, because `PRESCALE` ≥2 and presses are ≥2 cycles apart by construction.
- **`run` to mode change:** `mode` changes 2 edges after `run` is first sampled, i.e. synchronizer latency only.

## Test plan
1. **Reset:** `r`=1 for 3 cycles with `key`=1 and `run`=1 → `EC`=1, `key_db`=0, `mode`=00 throughout. After release, `mode`=01 two edges later.
2. **Clean step press:** `DEBOUNCE_CYCLES`=4, `key` 0→1 held 20 cycles →
   - `key_db` rises at edge 5;
   - one `EC` low pulse of 1 period, from the falling edge after edge 5;
   - releasing `key` produces no pulse.
3. **Bounce:** `key` = 1,0,1,0 (2 cycles each), then 1 for 12 cycles → `key_db` rises only after 4 stable counts; exactly one `EC` pulse.
4. **Free-run:** `PRESCALE`=10, `run`=1 for 35 cycles after `mode`=01 → `EC` pulses at cycles 10, 20 and 30 only. `run`=0 → `mode`=00, no further pulses.
5. **Pause and resume:**
   - Press while in RUN with prescaler=3 → `mode`=10, no pulses for 30 cycles.
   - Press again → `mode`=01, next pulse 7 cycles after resume.
6. **Priority and reset mid-run:**
   - `run` 1→0 synced on the same edge as a `press` → `mode`=00, no pulse.
   - `r` asserted during an `EC` low period → `EC` high at the next falling edge, then stays 1.
